// File: rtl/result_writeback_pkg.sv
// result_writeback_pkg: shared computation-stage encodings for the result write-back block.
package result_writeback_pkg;
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WRITE     = 2'd1;
    localparam logic [1:0] ST_DONE      = 2'd2;
    localparam logic [1:0] SRC_SYSTOLIC = 2'b01;
    localparam logic [1:0] SRC_CUSTOM   = 2'b10;
    localparam int         NUM_RESULTS  = 4;

    function automatic logic src_legal(input logic [1:0] s);
        return s == SRC_SYSTOLIC || s == SRC_CUSTOM;
    endfunction
endpackage

// File: rtl/result_capture_regs.sv
// result_capture_regs: 4-entry result register file with parallel load and indexed read.
module result_capture_regs
    import result_writeback_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                          clk,
    input  logic                          clr,
    input  logic                          load,
    input  logic [NUM_RESULTS*DATA_W-1:0] ld_data,
    input  logic [1:0]                    rd_idx,
    output logic [DATA_W-1:0]             rd_data
);
    logic [DATA_W-1:0] regs_q [NUM_RESULTS];

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_RESULTS; i++)
            regs_q[i] <= clr ? '0 : load ? ld_data[i*DATA_W +: DATA_W] : regs_q[i];
    end

    assign rd_data = regs_q[rd_idx];
endmodule

// File: rtl/result_writeback.sv
// result_writeback: captures four results on start and writes them to memory from a base address.
module result_writeback
    import result_writeback_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        src_sel,
    input  logic [ADDR_W-1:0] result_base,
    input  logic [DATA_W-1:0] c11_sa,
    input  logic [DATA_W-1:0] c12_sa,
    input  logic [DATA_W-1:0] c21_sa,
    input  logic [DATA_W-1:0] c22_sa,
    input  logic [DATA_W-1:0] c11_custom,
    input  logic [DATA_W-1:0] c12_custom,
    input  logic [DATA_W-1:0] c21_custom,
    input  logic [DATA_W-1:0] c22_custom,
    output logic              wen,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic              err
);
    logic [1:0]                    state_q, state_d, idx_q, idx_d;
    logic [ADDR_W-1:0]             base_q, base_d, addr_q, addr_d;
    logic [DATA_W-1:0]             wdata_q, wdata_d, cap_rd;
    logic                          wen_q, wen_d, busy_q, busy_d, done_q, done_d, err_q, err_d, load;
    logic [NUM_RESULTS*DATA_W-1:0] sel_vec;

    assign sel_vec = (src_sel == SRC_CUSTOM) ? {c22_custom, c21_custom, c12_custom, c11_custom}
                                             : {c22_sa, c21_sa, c12_sa, c11_sa};

    result_capture_regs #(.DATA_W(DATA_W)) u_cap (
        .clk    (clk),
        .clr    (rst),
        .load   (load),
        .ld_data(sel_vec),
        .rd_idx (idx_q),
        .rd_data(cap_rd)
    );

    // Word 0 goes out straight from the inputs on the capture edge; idx then counts the next word.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        base_d  = base_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        busy_d  = busy_q;
        wen_d   = 1'b0;
        done_d  = 1'b0;
        load    = 1'b0;
        err_d   = err_q | (start & ((state_q != ST_IDLE) | ~src_legal(src_sel)));
        case (state_q)
            ST_IDLE: if (start && src_legal(src_sel)) begin
                load    = 1'b1;
                base_d  = result_base;
                idx_d   = 2'd1;
                wen_d   = 1'b1;
                addr_d  = result_base;
                wdata_d = sel_vec[DATA_W-1:0];
                busy_d  = 1'b1;
                state_d = ST_WRITE;
            end
            ST_WRITE: if (idx_q == 2'd0) begin
                done_d  = 1'b1;
                state_d = ST_DONE;
            end else begin
                wen_d   = 1'b1;
                addr_d  = base_q + ADDR_W'(idx_q);
                wdata_d = cap_rd;
                idx_d   = idx_q + 2'd1;
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            base_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wen_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            base_q  <= base_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wen_q   <= wen_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign wen   = wen_q;
    assign addr  = addr_q;
    assign wdata = wdata_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign err   = err_q;
endmodule
